life_ctrl: RTL and testbench
============================

# life_ctrl

Player-life and game-state controller for the platformer. Consumes the per-hazard `death` strobes (poison star and later hazards, OR-ed upstream) and the frame tick, and decides when the character dies, plays the death sequence, respawns, or reaches game over. Its outputs drive the character/physics blocks (freeze, respawn) and the renderer (lives, blink, death animation), so it sits directly downstream of the hazard-collision stage.

## Interface
Parameters:
- `INIT_LIVES`, 3: lives loaded on game start; range 1..7.
- `DEATH_FRAMES`, 48: frames spent in the death sequence.
- `INVULN_FRAMES`, 90: post-respawn frames during which hazards are ignored.
- `GAMEOVER_FRAMES`, 120: minimum frames on the game-over screen before start is accepted.

Ports:
- `sys_clk`  in  1  system clock.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `death_in`  in  1  OR of hazard `death` outputs, level, combinational upstream.
- `hazard_en`  in  1  OR of hazard `en`; death is only honoured when high.
- `start_btn`  in  1  raw start button, asynchronous to `sys_clk`.
- `lives`  out  3  remaining lives.
- `game_state`  out  3  current state encoding.
- `freeze`  out  1  high: physics and scrolling must hold.
- `respawn`  out  1  one-cycle pulse: reset character position and `bg_pos`.
- `blink`  out  1  renderer hides character when high.
- `anim_frame`  out  8  frame index within the death sequence.
- `game_over`  out  1  high in GAME_OVER.

## Operation
- States: IDLE, PLAY, DYING, RESPAWN, GAME_OVER.
- IDLE: `freeze`=1. Start rising edge → PLAY, `lives`←INIT_LIVES, `respawn` pulse, invuln counter←0.
- PLAY: `freeze`=0. On a cycle with `frame_tick`=1: if invuln counter>0, decrement it; else if `death_in`&`hazard_en` → DYING, `anim_frame`←0.
- `blink` = (invuln counter>0) & invuln counter[2] in PLAY; 0 elsewhere.
- DYING: `freeze`=1; `anim_frame` increments per `frame_tick`. When `anim_frame`=DEATH_FRAMES-1 at a tick: `lives`←`lives`-1; go to GAME_OVER if old `lives`=1, else RESPAWN.
- RESPAWN: exactly one cycle; `respawn`=1; invuln counter←INVULN_FRAMES; → PLAY.
- GAME_OVER: `freeze`=1, `game_over`=1; wait counter counts ticks up to GAMEOVER_FRAMES (saturating); start rising edge accepted only once saturated → IDLE.
- `start_btn`: 2-flop synchroniser plus rising-edge detect; edges ignored in PLAY, DYING, RESPAWN, and in GAME_OVER before saturation (not queued).
- `lives` never underflows; decrement only in the DYING exit path.
- `death_in` is ignored outside PLAY and while invulnerable, including re-assertion during DYING.

## Timing
- Reset values: state IDLE, `lives`=0, `freeze`=1, `respawn`=0, `blink`=0, `anim_frame`=0, `game_over`=0, all counters 0, synchroniser flops 0.
- All outputs registered; state changes on the `sys_clk` edge where the condition is sampled.
- Death latency: `death_in`&`hazard_en` high on a `frame_tick` cycle → DYING and `freeze`=1 on the next cycle.
- Start latency: 3 cycles from `start_btn` rising (2 sync + edge register) to state change.
- Death sequence: DEATH_FRAMES ticks; RESPAWN one cycle; PLAY with `freeze`=0 on the following cycle.
- `RST_N` low mid-sequence: immediate return to reset values; no `respawn` pulse until the next start.

## Structure
- Shared package `game_pkg`: state encoding constants, default frame-count constants, `LIVES_W`=3.
- Sub-module `btn_sync_edge` (2-flop synchroniser + rising-edge pulse), reused for future buttons.
- Counters: 8-bit `anim_frame`, 7-bit invuln, 7-bit game-over wait; widths checked against parameter defaults.

## Test plan
- Reset, start pulse → after 3 cycles state PLAY, `lives`=3, one `respawn` pulse, `freeze`=0.
- `death_in`=`hazard_en`=1 on a tick while not invulnerable → DYING next cycle; 48 ticks later RESPAWN, `lives`=2, then PLAY with `blink` toggling every 4 ticks for 90 ticks.
- `death_in`=1 during invulnerability or with `hazard_en`=0 → stays PLAY, `lives` unchanged.
- Three deaths → GAME_OVER, `lives`=0, `game_over`=1; start at tick 50 ignored, start after tick 120 → IDLE.
- `RST_N` low at `anim_frame`=20 in DYING → IDLE, `lives`=0, `freeze`=1, no `respawn` pulse.
- `death_in` and start edge in the same PLAY cycle → DYING; start ignored.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-control types and constants: state encoding, default frame counts, counter widths.
// Contents: game_state_e, LIVES_W, ANIM_W, INVULN_W, GO_WAIT_W, DEF_* frame-count defaults.
// Imported by life_ctrl and by any block that decodes game_state.
package game_pkg;

    localparam int LIVES_W   = 3;
    localparam int ANIM_W    = 8;
    localparam int INVULN_W  = 7;
    localparam int GO_WAIT_W = 7;

    localparam int DEF_INIT_LIVES      = 3;
    localparam int DEF_DEATH_FRAMES    = 48;
    localparam int DEF_INVULN_FRAMES   = 90;
    localparam int DEF_GAMEOVER_FRAMES = 120;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_RESPAWN   = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button, followed by a rising-edge pulse.
// Ports: clk_i, rst_ni (async active-low), btn_i (raw async), rise_o (one-cycle pulse).
// rise_o is high in the cycle after the second sync flop first sees the button high,
// so a consumer registering on rise_o changes state 3 clocks after the button rises.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/life_ctrl.sv
// Player-life and game-state controller: death detection, death sequence, respawn, game over.
// Ports: sys_clk, RST_N (async active-low), frame_tick, death_in, hazard_en, start_btn in;
//        lives, game_state, freeze, respawn, blink, anim_frame, game_over out (all registered).
// Start edges arriving in states that do not accept them are dropped, never queued.
module life_ctrl
    import game_pkg::*;
#(
    parameter int INIT_LIVES      = DEF_INIT_LIVES,
    parameter int DEATH_FRAMES    = DEF_DEATH_FRAMES,
    parameter int INVULN_FRAMES   = DEF_INVULN_FRAMES,
    parameter int GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES
) (
    input  logic               sys_clk,
    input  logic               RST_N,
    input  logic               frame_tick,
    input  logic               death_in,
    input  logic               hazard_en,
    input  logic               start_btn,
    output logic [LIVES_W-1:0] lives,
    output logic [2:0]         game_state,
    output logic               freeze,
    output logic               respawn,
    output logic               blink,
    output logic [ANIM_W-1:0]  anim_frame,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0]   LIVES_LOAD = LIVES_W'(INIT_LIVES);
    localparam logic [ANIM_W-1:0]    ANIM_LAST  = ANIM_W'(DEATH_FRAMES - 1);
    localparam logic [INVULN_W-1:0]  INV_LOAD   = INVULN_W'(INVULN_FRAMES);
    localparam logic [GO_WAIT_W-1:0] WAIT_SAT   = GO_WAIT_W'(GAMEOVER_FRAMES);

    logic start_rise;

    btn_sync_edge u_start_sync (
        .clk_i  (sys_clk),
        .rst_ni (RST_N),
        .btn_i  (start_btn),
        .rise_o (start_rise)
    );

    game_state_e          state_q,   state_d;
    logic [LIVES_W-1:0]   lives_q,   lives_d;
    logic [INVULN_W-1:0]  inv_q,     inv_d;
    logic [ANIM_W-1:0]    anim_q,    anim_d;
    logic [GO_WAIT_W-1:0] wait_q,    wait_d;
    logic                 respawn_q, respawn_d;
    logic                 freeze_q;
    logic                 blink_q;
    logic                 game_over_q;

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        inv_d     = inv_q;
        anim_d    = anim_q;
        wait_d    = wait_q;
        respawn_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d   = ST_PLAY;
                    lives_d   = LIVES_LOAD;
                    inv_d     = '0;
                    respawn_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // Invulnerability consumes the tick, so a hazard on that tick is ignored.
                if (frame_tick) begin
                    if (inv_q != '0) begin
                        inv_d = inv_q - 1'b1;
                    end else if (death_in && hazard_en) begin
                        state_d = ST_DYING;
                        anim_d  = '0;
                    end
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (anim_q == ANIM_LAST) begin
                        if (lives_q != '0) begin
                            lives_d = lives_q - 1'b1;
                        end
                        if (lives_q <= LIVES_W'(1)) begin
                            state_d = ST_GAME_OVER;
                            wait_d  = '0;
                        end else begin
                            state_d   = ST_RESPAWN;
                            respawn_d = 1'b1;
                        end
                    end else begin
                        anim_d = anim_q + 1'b1;
                    end
                end
            end
            ST_RESPAWN: begin
                inv_d   = INV_LOAD;
                state_d = ST_PLAY;
            end
            ST_GAME_OVER: begin
                if (frame_tick && (wait_q != WAIT_SAT)) begin
                    wait_d = wait_q + 1'b1;
                end
                if (start_rise && (wait_q == WAIT_SAT)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with game_state.
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            lives_q     <= '0;
            inv_q       <= '0;
            anim_q      <= '0;
            wait_q      <= '0;
            respawn_q   <= 1'b0;
            freeze_q    <= 1'b1;
            blink_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            inv_q       <= inv_d;
            anim_q      <= anim_d;
            wait_q      <= wait_d;
            respawn_q   <= respawn_d;
            freeze_q    <= (state_d != ST_PLAY);
            blink_q     <= (state_d == ST_PLAY) && (inv_d != '0) && inv_d[2];
            game_over_q <= (state_d == ST_GAME_OVER);
        end
    end

    assign lives      = lives_q;
    assign game_state = state_q;
    assign freeze     = freeze_q;
    assign respawn    = respawn_q;
    assign blink      = blink_q;
    assign anim_frame = anim_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl: start latency, death/respawn, invulnerability blink,
// game-over wait boundary, asynchronous reset mid-sequence.
// Frame ticks are issued every other clock; outputs sampled 1 time unit after posedge.
module tb_life_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PLAY  = 3'd1;
    localparam logic [2:0] S_DYING = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_GOVER = 3'd4;

    logic       sys_clk    = 1'b0;
    logic       RST_N      = 1'b0;
    logic       frame_tick = 1'b0;
    logic       death_in   = 1'b0;
    logic       hazard_en  = 1'b0;
    logic       start_btn  = 1'b0;
    logic [2:0] lives;
    logic [2:0] game_state;
    logic       freeze;
    logic       respawn;
    logic       blink;
    logic [7:0] anim_frame;
    logic       game_over;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    life_ctrl dut (
        .sys_clk    (sys_clk),
        .RST_N      (RST_N),
        .frame_tick (frame_tick),
        .death_in   (death_in),
        .hazard_en  (hazard_en),
        .start_btn  (start_btn),
        .lives      (lives),
        .game_state (game_state),
        .freeze     (freeze),
        .respawn    (respawn),
        .blink      (blink),
        .anim_frame (anim_frame),
        .game_over  (game_over)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        cyc(3);
        start_btn = 1'b0;
        cyc(3);
    endtask

    initial begin
        int seen;

        // Reset values
        cyc(3);
        check("rst_state", 32'(game_state), 32'(S_IDLE));
        check("rst_lives", 32'(lives), 0);
        check("rst_freeze", 32'(freeze), 1);
        check("rst_respawn", 32'(respawn), 0);
        check("rst_blink", 32'(blink), 0);
        check("rst_anim", 32'(anim_frame), 0);
        check("rst_gameover", 32'(game_over), 0);

        // Start: state changes on the third edge after the button rises
        RST_N = 1'b1;
        cyc(1);
        start_btn = 1'b1;
        cyc(2);
        check("start_not_yet", 32'(game_state), 32'(S_IDLE));
        cyc(1);
        check("start_state", 32'(game_state), 32'(S_PLAY));
        check("start_lives", 32'(lives), 3);
        check("start_respawn", 32'(respawn), 1);
        check("start_freeze", 32'(freeze), 0);
        cyc(1);
        check("start_respawn_end", 32'(respawn), 0);
        start_btn = 1'b0;
        cyc(4);

        // Death with hazard disabled is ignored
        death_in  = 1'b1;
        hazard_en = 1'b0;
        ticks(2);
        check("haz_off_state", 32'(game_state), 32'(S_PLAY));
        check("haz_off_lives", 32'(lives), 3);

        // Death and start edge on the same PLAY tick
        death_in  = 1'b0;
        start_btn = 1'b1;
        cyc(2);
        death_in   = 1'b1;
        hazard_en  = 1'b1;
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        check("die_state", 32'(game_state), 32'(S_DYING));
        check("die_freeze", 32'(freeze), 1);
        check("die_anim", 32'(anim_frame), 0);
        check("die_lives", 32'(lives), 3);
        cyc(1);
        start_btn = 1'b0;
        cyc(3);
        check("start_ign_dying", 32'(game_state), 32'(S_DYING));

        // Death sequence with death_in held high throughout
        ticks(47);
        check("anim_last", 32'(anim_frame), 47);
        check("anim_last_state", 32'(game_state), 32'(S_DYING));
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        check("resp_state", 32'(game_state), 32'(S_RESP));
        check("resp_lives", 32'(lives), 2);
        check("resp_pulse", 32'(respawn), 1);
        check("resp_freeze", 32'(freeze), 1);
        cyc(1);
        check("play2_state", 32'(game_state), 32'(S_PLAY));
        check("play2_freeze", 32'(freeze), 0);
        check("play2_respawn", 32'(respawn), 0);
        check("play2_blink90", 32'(blink), 0);

        // Invulnerability: 90 ticks, death ignored, blink follows counter bit 2
        ticks(3);
        check("blink_inv87", 32'(blink), 1);
        ticks(4);
        check("blink_inv83", 32'(blink), 0);
        ticks(4);
        check("blink_inv79", 32'(blink), 1);
        ticks(75);
        check("blink_inv4", 32'(blink), 1);
        ticks(2);
        check("blink_inv2", 32'(blink), 0);
        ticks(2);
        check("inv_end_blink", 32'(blink), 0);
        check("inv_end_state", 32'(game_state), 32'(S_PLAY));
        check("inv_end_lives", 32'(lives), 2);

        // Second and third deaths
        ticks(1);
        check("die2_state", 32'(game_state), 32'(S_DYING));
        ticks(48);
        check("die2_play", 32'(game_state), 32'(S_PLAY));
        check("die2_lives", 32'(lives), 1);
        ticks(90);
        ticks(1);
        check("die3_state", 32'(game_state), 32'(S_DYING));
        ticks(48);
        check("go_state", 32'(game_state), 32'(S_GOVER));
        check("go_lives", 32'(lives), 0);
        check("go_flag", 32'(game_over), 1);
        check("go_freeze", 32'(freeze), 1);

        // Game-over wait: start ignored before 120 ticks
        ticks(50);
        press_start();
        check("go_start_t50", 32'(game_state), 32'(S_GOVER));
        ticks(69);
        press_start();
        check("go_start_t119", 32'(game_state), 32'(S_GOVER));
        ticks(1);
        press_start();
        check("go_exit_state", 32'(game_state), 32'(S_IDLE));
        check("go_exit_flag", 32'(game_over), 0);
        check("go_exit_freeze", 32'(freeze), 1);
        check("go_exit_lives", 32'(lives), 0);

        // Asynchronous reset at anim_frame 20
        press_start();
        check("rs_play", 32'(game_state), 32'(S_PLAY));
        ticks(1);
        check("rs_dying", 32'(game_state), 32'(S_DYING));
        ticks(20);
        check("rs_anim20", 32'(anim_frame), 20);
        #2;
        RST_N = 1'b0;
        #1;
        check("rs_state", 32'(game_state), 32'(S_IDLE));
        check("rs_lives", 32'(lives), 0);
        check("rs_freeze", 32'(freeze), 1);
        check("rs_anim", 32'(anim_frame), 0);
        check("rs_respawn", 32'(respawn), 0);
        death_in = 1'b0;
        cyc(2);
        RST_N = 1'b1;
        seen = 0;
        repeat (10) begin
            cyc(1);
            if (respawn) seen++;
        end
        check("rs_no_respawn", 32'(seen), 0);
        check("rs_idle_after", 32'(game_state), 32'(S_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
